// File: rtl/video_ram_dp.sv
// rtl/video_ram_dp.sv - true dual-port video RAM with registered reads and a sequential clear engine
// Optional registered collision pulse output: define VIDEO_RAM_DP_COLLISION_EN
module video_ram_dp #(
    parameter int                    DATA_WIDTH    = 4,
    parameter int                    ADDR_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    parameter bit                    WRITE_THROUGH = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  clear_busy,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    output logic [DATA_WIDTH-1:0] q_b
`ifdef VIDEO_RAM_DP_COLLISION_EN
    ,
    output logic                  collision
`endif
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clearing, same_addr, we_a, we_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign clearing   = (state == CLEAR);
    assign clear_busy = clearing;
    assign same_addr  = (address_a == address_b);
    // Port B owns the location on a same-address double write.
    assign we_b       = wren_b && !clearing;
    assign we_a       = wren_a && !clearing && !(we_b && same_addr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == '1) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                clr_addr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clearing) mem[clr_addr]  <= CLEAR_VALUE;
        if (we_a)     mem[address_a] <= data_a;
        if (we_b)     mem[address_b] <= data_b;
    end

    // Write-through forwards this edge's winning write (user or clear) into the read register.
    always_comb begin
        rd_a = mem[address_a];
        rd_b = mem[address_b];
        if (WRITE_THROUGH) begin
            if (we_b && same_addr)                      rd_a = data_b;
            else if (we_a)                              rd_a = data_a;
            else if (clearing && clr_addr == address_a) rd_a = CLEAR_VALUE;

            if (we_b)                                   rd_b = data_b;
            else if (we_a && same_addr)                 rd_b = data_a;
            else if (clearing && clr_addr == address_b) rd_b = CLEAR_VALUE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= rd_a;
            q_b <= rd_b;
        end
    end

`ifdef VIDEO_RAM_DP_COLLISION_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) collision <= 1'b0;
        else          collision <= wren_a && wren_b && same_addr && !clearing;
    end
`endif

endmodule

// File: tb/tb_video_ram_dp.sv
// tb/tb_video_ram_dp.sv - randomized and directed check of video_ram_dp against a behavioural model
// dut0: default 4x256 read-old; dut1: 8x1024 write-through, CLEAR_VALUE 0x3C
module tb_video_ram_dp;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_req = 1'b0;
    logic [9:0] ad_a = '0, ad_b = '0;
    logic [7:0] dt_a = '0, dt_b = '0;
    logic       wren_a = 1'b0, wren_b = 1'b0;

    logic [3:0] q_a0, q_b0;
    logic [7:0] q_a1, q_b1;
    logic       busy0, busy1;
    logic       coll0, coll1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    video_ram_dp dut0 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy0),
        .address_a(ad_a[7:0]), .data_a(dt_a[3:0]), .wren_a(wren_a), .q_a(q_a0),
        .address_b(ad_b[7:0]), .data_b(dt_b[3:0]), .wren_b(wren_b), .q_b(q_b0)
`ifdef VIDEO_RAM_DP_COLLISION_EN
        , .collision(coll0)
`endif
    );

    video_ram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CLEAR_VALUE(8'h3C), .WRITE_THROUGH(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy1),
        .address_a(ad_a), .data_a(dt_a), .wren_a(wren_a), .q_a(q_a1),
        .address_b(ad_b), .data_b(dt_b), .wren_b(wren_b), .q_b(q_b1)
`ifdef VIDEO_RAM_DP_COLLISION_EN
        , .collision(coll1)
`endif
    );

`ifndef VIDEO_RAM_DP_COLLISION_EN
    assign coll0 = 1'b0;
    assign coll1 = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: array contents plus a known-flag per word, both RAM flavours side by side.
    logic [7:0] m_mem   [2][1024];
    bit         m_known [2][1024];
    logic [7:0] m_qa [2], m_qb [2];
    bit         m_qa_k [2] = '{0, 0}, m_qb_k [2] = '{0, 0};
    bit         m_busy [2] = '{0, 0};
    bit         m_coll [2] = '{0, 0};
    int         m_idx  [2];

    always @(posedge clock or negedge reset_n) begin : model
        int         ma, mb, depth;
        logic [7:0] da, db, cv, dmask;
        bit         wa, wb, wt;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_qa[k] = '0; m_qb[k] = '0; m_qa_k[k] = 1; m_qb_k[k] = 1;
                m_busy[k] = 0; m_coll[k] = 0; m_idx[k] = 0;
            end else begin
                depth = (k == 0) ? 256 : 1024;
                dmask = (k == 0) ? 8'h0F : 8'hFF;
                cv    = (k == 0) ? 8'h00 : 8'h3C;
                wt    = (k == 1);
                ma = int'(ad_a) % depth;
                mb = int'(ad_b) % depth;
                da = dt_a & dmask;
                db = dt_b & dmask;
                wa = wren_a && !m_busy[k];
                wb = wren_b && !m_busy[k];
                m_coll[k] = wa && wb && (ma == mb);
                if (!wt) begin
                    m_qa[k] = m_mem[k][ma]; m_qa_k[k] = m_known[k][ma];
                    m_qb[k] = m_mem[k][mb]; m_qb_k[k] = m_known[k][mb];
                end
                if (m_busy[k]) begin
                    m_mem[k][m_idx[k]] = cv; m_known[k][m_idx[k]] = 1;
                end
                if (wa) begin m_mem[k][ma] = da; m_known[k][ma] = 1; end
                if (wb) begin m_mem[k][mb] = db; m_known[k][mb] = 1; end
                if (wt) begin
                    m_qa[k] = m_mem[k][ma]; m_qa_k[k] = m_known[k][ma];
                    m_qb[k] = m_mem[k][mb]; m_qb_k[k] = m_known[k][mb];
                end
                if (m_busy[k]) begin
                    m_idx[k]++;
                    if (m_idx[k] == depth) m_busy[k] = 0;
                end else if (clear_req) begin
                    m_busy[k] = 1;
                    m_idx[k] = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("busy0", 32'(busy0), 32'(m_busy[0]));
        check("busy1", 32'(busy1), 32'(m_busy[1]));
        if (m_qa_k[0]) check("q_a0", 32'(q_a0), 32'(m_qa[0]));
        if (m_qb_k[0]) check("q_b0", 32'(q_b0), 32'(m_qb[0]));
        if (m_qa_k[1]) check("q_a1", 32'(q_a1), 32'(m_qa[1]));
        if (m_qb_k[1]) check("q_b1", 32'(q_b1), 32'(m_qb[1]));
`ifdef VIDEO_RAM_DP_COLLISION_EN
        check("coll0", 32'(coll0), 32'(m_coll[0]));
        check("coll1", 32'(coll1), 32'(m_coll[1]));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 1024; i++) begin
            ad_a = 10'(i); ad_b = 10'(i); dt_a = 8'hFF; wren_a = 1'b1;
            tick();
        end
        wren_a = 1'b0;
    endtask

    task automatic read_a(input logic [9:0] addr);
        ad_a = addr; wren_a = 1'b0; wren_b = 1'b0;
        tick();
    endtask

    initial begin : stim
        int c0, c1;
        tick(); tick();
        check("reset_q_a0", 32'(q_a0), 32'h0);
        check("reset_q_b1", 32'(q_b1), 32'h0);
        check("reset_busy0", 32'(busy0), 32'h0);
        check("reset_busy1", 32'(busy1), 32'h0);
        reset_n = 1'b1;
        tick();
        fill_ff();

        // read-old vs write-through on a same-cycle write at 0x10
        ad_a = 10'h010; dt_a = 8'h0A; wren_a = 1'b1; ad_b = 10'h010;
        tick();
        check("old_q_b0", 32'(q_b0), 32'hF);
        check("model_old_q_b0", 32'(m_qb[0]), 32'hF);
        check("wt_q_a1", 32'(q_a1), 32'h0A);
        wren_a = 1'b0;
        tick();
        check("next_q_b0", 32'(q_b0), 32'hA);

        ad_a = 10'h020; dt_a = 8'h05; wren_a = 1'b1;
        tick();
        check("wt20_q_a1", 32'(q_a1), 32'h05);
        check("old20_q_a0", 32'(q_a0), 32'hF);

        // collision at 0x30: port B wins
        ad_a = 10'h030; ad_b = 10'h030; dt_a = 8'h03; dt_b = 8'h0C; wren_a = 1'b1; wren_b = 1'b1;
        tick();
        check("coll_wt_q_a1", 32'(q_a1), 32'h0C);
        check("coll_old_q_a0", 32'(q_a0), 32'hF);
`ifdef VIDEO_RAM_DP_COLLISION_EN
        check("coll_pulse0", 32'(coll0), 32'h1);
`endif
        wren_a = 1'b0; wren_b = 1'b0;
        tick();
        check("coll_q_a0", 32'(q_a0), 32'hC);
        check("coll_q_b0", 32'(q_b0), 32'hC);
`ifdef VIDEO_RAM_DP_COLLISION_EN
        check("coll_drop0", 32'(coll0), 32'h0);
`endif

        ad_a = 10'h3FF; dt_a = 8'hA5; wren_a = 1'b1;
        tick();
        read_a(10'h3FF);
        check("top_q_a1", 32'(q_a1), 32'hA5);
        check("top_q_a0", 32'(q_a0), 32'h5);

        // full clear with a write attempted mid-clear
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 1100; i++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            wren_a = (i == 10);
            ad_a = 10'h005; dt_a = 8'h01;
            tick();
        end
        wren_a = 1'b0;
        check("clear_len0", 32'(c0), 32'd256);
        check("clear_len1", 32'(c1), 32'd1024);
        for (int i = 0; i < 1024; i++) begin
            ad_a = 10'(i); ad_b = 10'(1023 - i);
            tick();
        end
        read_a(10'h005);
        check("cleared_q_a0", 32'(q_a0), 32'h0);
        check("cleared_q_a1", 32'(q_a1), 32'h3C);

        // reset at clear cycle 100
        fill_ff();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h0);
        check("rst_q_a0", 32'(q_a0), 32'h0);
        check("rst_q_a1", 32'(q_a1), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        read_a(10'd50);
        check("part_lo_q_a0", 32'(q_a0), 32'h0);
        check("part_lo_q_a1", 32'(q_a1), 32'h3C);
        read_a(10'd200);
        check("part_hi_q_a0", 32'(q_a0), 32'hF);
        read_a(10'd500);
        check("part_hi_q_a1", 32'(q_a1), 32'hFF);
        for (int i = 0; i < 1024; i++) begin
            ad_a = 10'(i); ad_b = 10'(i ^ 10'h155);
            tick();
        end

        // random traffic, biased toward address collisions, with rare clears
        for (int i = 0; i < 4000; i++) begin
            ad_a = 10'($urandom_range(0, 1023));
            ad_b = ($urandom_range(0, 3) == 0) ? ad_a : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) begin
                ad_a = ad_a & 10'h00F; ad_b = ad_b & 10'h00F;
            end
            dt_a = 8'($urandom); dt_b = 8'($urandom);
            wren_a = 1'($urandom); wren_b = 1'($urandom);
            clear_req = ($urandom_range(0, 799) == 0);
            tick();
        end
        clear_req = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
